uart_cmd_frame_parser: RTL and testbench

//  Consumes the byte stream of the multi-baud UART receiver (data_byte + one-cycle Rx_Done) and parses command frames.

---
 rtl/uart_cmd_frame_parser_pkg.sv | 23 ++
 rtl/uart_cmd_frame_parser_payload_buf.sv | 28 ++
 rtl/uart_cmd_frame_parser.sv | 207 ++++++++++++++++++++
 tb/tb_uart_cmd_frame_parser.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_frame_parser_pkg.sv
// Shared constants for the UART command frame parser: header bytes, FSM states, error codes.
package uart_cmd_frame_parser_pkg;

    localparam logic [7:0] HDR0_BYTE = 8'h55;
    localparam logic [7:0] HDR1_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_HDR0 = 3'd0,
        ST_HDR1 = 3'd1,
        ST_CMD  = 3'd2,
        ST_ADDR = 3'd3,
        ST_LEN  = 3'd4,
        ST_DATA = 3'd5,
        ST_CSUM = 3'd6,
        ST_EMIT = 3'd7
    } state_t;

    localparam logic [1:0] ERR_CSUM    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

endpackage

// File: rtl/uart_cmd_frame_parser_payload_buf.sv
// Payload holding buffer: MAX_LEN x 8 register array, synchronous write, combinational read.
module uart_cmd_frame_parser_payload_buf #(
    parameter int MAX_LEN = 16,
    parameter int IW      = $clog2(MAX_LEN + 1)
) (
    input  logic          Clk,
    input  logic          i_we,
    input  logic [IW-1:0] i_widx,
    input  logic [7:0]    i_wdata,
    input  logic [IW-1:0] i_ridx,
    output logic [7:0]    o_rdata
);

    localparam int            AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [IW-1:0] LAST = IW'(MAX_LEN - 1);

    logic [7:0] r_mem [MAX_LEN];

    always_ff @(posedge Clk) begin
        if (i_we && (i_widx <= LAST)) begin
            r_mem[i_widx[AW-1:0]] <= i_wdata;
        end
    end

    // Out-of-range reads (index one past the last byte during the burst) return zero.
    assign o_rdata = (i_ridx <= LAST) ? r_mem[i_ridx[AW-1:0]] : 8'h00;

endmodule

// File: rtl/uart_cmd_frame_parser.sv
// Parses 55 A5 CMD ADDR LEN DATA.. CSUM frames from a UART byte stream and releases
// the checked payload as a burst of register writes.
module uart_cmd_frame_parser
    import uart_cmd_frame_parser_pkg::*;
#(
    parameter int MAX_LEN      = 16,
    parameter int TIMEOUT_CLKS = 50000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Rx_Done,
    input  logic [7:0] data_byte,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [7:0] cmd,
    output logic       frame_done,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy,
    output logic [2:0] dbg_state
);

    localparam int            IW        = $clog2(MAX_LEN + 1);
    localparam int            TW        = $clog2(TIMEOUT_CLKS);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    state_t        r_state;
    logic [7:0]    r_sum;
    logic [7:0]    r_pend_cmd;
    logic [7:0]    r_addr;
    logic [7:0]    r_len;
    logic [IW-1:0] r_idx;
    logic [TW-1:0] r_tmo;
    logic          r_overrun;
    logic          r_wr_en;
    logic [7:0]    r_wr_addr;
    logic [7:0]    r_wr_data;
    logic [7:0]    r_cmd;
    logic          r_frame_done;
    logic          r_frame_err;
    logic [1:0]    r_err_code;

    logic          w_buf_we;
    logic [IW-1:0] w_rd_idx;
    logic [7:0]    w_rd_data;
    logic          w_in_frame;
    logic          w_last_emit;

    assign w_buf_we    = (r_state == ST_DATA) && Rx_Done;
    // During EMIT the byte for the next cycle is prefetched; entering EMIT reads byte 0.
    assign w_rd_idx    = (r_state == ST_EMIT) ? r_idx + 1'b1 : '0;
    assign w_in_frame  = (r_state != ST_HDR0) && (r_state != ST_EMIT);
    assign w_last_emit = (8'(r_idx) == r_len - 8'd1);

    uart_cmd_frame_parser_payload_buf #(
        .MAX_LEN (MAX_LEN),
        .IW      (IW)
    ) u_buf (
        .Clk     (Clk),
        .i_we    (w_buf_we),
        .i_widx  (r_idx),
        .i_wdata (data_byte),
        .i_ridx  (w_rd_idx),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state      <= ST_HDR0;
            r_sum        <= 8'h00;
            r_pend_cmd   <= 8'h00;
            r_addr       <= 8'h00;
            r_len        <= 8'h00;
            r_idx        <= '0;
            r_tmo        <= '0;
            r_overrun    <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= 8'h00;
            r_wr_data    <= 8'h00;
            r_cmd        <= 8'h00;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_err_code   <= 2'd0;
        end else begin
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_tmo        <= (w_in_frame && !Rx_Done) ? r_tmo + 1'b1 : '0;

            // A byte arriving on the terminal count keeps the frame alive.
            if (w_in_frame && (r_tmo == TMO_LAST) && !Rx_Done) begin
                r_frame_err <= 1'b1;
                r_err_code  <= ERR_TIMEOUT;
                r_state     <= ST_HDR0;
            end else begin
                case (r_state)
                    ST_HDR0: begin
                        if (Rx_Done && (data_byte == HDR0_BYTE)) r_state <= ST_HDR1;
                    end
                    ST_HDR1: begin
                        if (Rx_Done) begin
                            if (data_byte == HDR1_BYTE) begin
                                r_sum   <= 8'h00;
                                r_state <= ST_CMD;
                            end else if (data_byte != HDR0_BYTE) begin
                                r_state <= ST_HDR0;
                            end
                        end
                    end
                    ST_CMD: begin
                        if (Rx_Done) begin
                            r_pend_cmd <= data_byte;
                            r_sum      <= r_sum + data_byte;
                            r_state    <= ST_ADDR;
                        end
                    end
                    ST_ADDR: begin
                        if (Rx_Done) begin
                            r_addr  <= data_byte;
                            r_sum   <= r_sum + data_byte;
                            r_state <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (Rx_Done) begin
                            r_len <= data_byte;
                            r_sum <= r_sum + data_byte;
                            r_idx <= '0;
                            if (data_byte > MAX_LEN_B) begin
                                r_frame_err <= 1'b1;
                                r_err_code  <= ERR_LEN;
                                r_state     <= ST_HDR0;
                            end else if (data_byte == 8'h00) begin
                                r_state <= ST_CSUM;
                            end else begin
                                r_state <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (Rx_Done) begin
                            r_sum <= r_sum + data_byte;
                            if (w_last_emit) begin
                                r_idx   <= '0;
                                r_state <= ST_CSUM;
                            end else begin
                                r_idx <= r_idx + 1'b1;
                            end
                        end
                    end
                    ST_CSUM: begin
                        if (Rx_Done) begin
                            if (data_byte == r_sum) begin
                                r_cmd     <= r_pend_cmd;
                                r_overrun <= 1'b0;
                                if (r_len == 8'h00) begin
                                    r_frame_done <= 1'b1;
                                    r_state      <= ST_HDR0;
                                end else begin
                                    r_wr_en   <= 1'b1;
                                    r_wr_addr <= r_addr;
                                    r_wr_data <= w_rd_data;
                                    r_state   <= ST_EMIT;
                                end
                            end else begin
                                r_frame_err <= 1'b1;
                                r_err_code  <= ERR_CSUM;
                                r_state     <= ST_HDR0;
                            end
                        end
                    end
                    ST_EMIT: begin
                        // Bytes arriving mid-burst are dropped and reported when the burst ends.
                        r_overrun <= r_overrun | Rx_Done;
                        if (w_last_emit) begin
                            r_frame_done <= 1'b1;
                            if (r_overrun || Rx_Done) begin
                                r_frame_err <= 1'b1;
                                r_err_code  <= ERR_OVERRUN;
                            end
                            r_state <= ST_HDR0;
                        end else begin
                            r_idx     <= r_idx + 1'b1;
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= r_addr + 8'(r_idx) + 8'd1;
                            r_wr_data <= w_rd_data;
                        end
                    end
                    default: r_state <= ST_HDR0;
                endcase
            end
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign cmd        = r_cmd;
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;
    assign err_code   = r_err_code;
    assign busy       = (r_state != ST_HDR0);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_uart_cmd_frame_parser.sv
// Directed bench for uart_cmd_frame_parser: frame table plus timeout, overrun and reset sequences.
module tb_uart_cmd_frame_parser;

    localparam int GAP     = 20;
    localparam int TIMEOUT = 50000;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Rx_Done;
    logic [7:0] data_byte;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] cmd;
    logic       frame_done;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;
    logic [2:0] dbg_state;

    uart_cmd_frame_parser #(
        .MAX_LEN      (16),
        .TIMEOUT_CLKS (TIMEOUT)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Rx_Done    (Rx_Done),
        .data_byte  (data_byte),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cmd        (cmd),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    always #10 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    int          rx_q[$];
    int          wr_cyc_q[$];
    logic [15:0] wr_q[$];
    int          done_q[$];
    int          err_cyc_q[$];
    logic [1:0]  err_code_q[$];
    logic [15:0] exp_q[$];

    logic [7:0] model_cmd  = 8'h00;
    logic [1:0] model_code = 2'd0;

    typedef struct {
        string      frame;
        string      wdata;
        logic [7:0] addr0;
        bit         done;
        bit         err;
        logic [1:0] code;
        logic [7:0] cmd;
    } vec_t;

    vec_t vecs[6];

    // output monitor, sampled mid-cycle
    always @(negedge Clk) begin
        cyc++;
        if (Rx_Done) rx_q.push_back(cyc);
        if (wr_en) begin
            wr_cyc_q.push_back(cyc);
            wr_q.push_back({wr_addr, wr_data});
        end
        if (frame_done) done_q.push_back(cyc);
        if (frame_err) begin
            err_cyc_q.push_back(cyc);
            err_code_q.push_back(err_code);
        end
    end

    function automatic logic [7:0] hex_at(input string s, input int i);
        string t;
        t = s.substr(2 * i, 2 * i + 1);
        return 8'(t.atohex());
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int k, input string fr, input string wd, input logic [7:0] a0,
                           input bit dn, input bit er, input logic [1:0] cd, input logic [7:0] cm);
        vecs[k].frame = fr;
        vecs[k].wdata = wd;
        vecs[k].addr0 = a0;
        vecs[k].done  = dn;
        vecs[k].err   = er;
        vecs[k].code  = cd;
        vecs[k].cmd   = cm;
    endtask

    task automatic clear_logs();
        rx_q.delete();
        wr_cyc_q.delete();
        wr_q.delete();
        done_q.delete();
        err_cyc_q.delete();
        err_code_q.delete();
        exp_q.delete();
    endtask

    // driver: one-cycle Rx_Done pulse followed by an idle gap
    task automatic send_byte(input logic [7:0] b, input int gap);
        @(posedge Clk); #1;
        Rx_Done   = 1'b1;
        data_byte = b;
        @(posedge Clk); #1;
        Rx_Done   = 1'b0;
        repeat (gap) @(posedge Clk);
        #1;
    endtask

    // scoreboard for one burst whose CSUM (or terminating) byte was seen in cycle n0
    task automatic check_burst(input string tag, input int n0, input string wd, input logic [7:0] a0,
                               input bit dn, input bit er, input logic [1:0] cd, input int err_at);
        int nwr;
        logic [15:0] got;
        nwr = wd.len() / 2;
        for (int i = 0; i < nwr; i++) exp_q.push_back({8'(a0 + 8'(i)), hex_at(wd, i)});
        chk({tag, " write count"}, wr_q.size(), nwr);
        for (int i = 0; i < nwr && wr_q.size() > 0; i++) begin
            got = wr_q.pop_front();
            chk($sformatf("%s write %0d addr/data", tag, i), got, exp_q.pop_front());
            chk($sformatf("%s write %0d cycle", tag, i), wr_cyc_q.pop_front(), n0 + 1 + i);
        end
        chk({tag, " frame_done count"}, done_q.size(), dn ? 1 : 0);
        if (dn && done_q.size() > 0) chk({tag, " frame_done cycle"}, done_q[0], n0 + nwr + 1);
        chk({tag, " frame_err count"}, err_cyc_q.size(), er ? 1 : 0);
        if (er && err_cyc_q.size() > 0) begin
            chk({tag, " frame_err cycle"}, err_cyc_q[0], err_at);
            chk({tag, " err_code"}, err_code_q[0], cd);
        end
    endtask

    task automatic post_checks(input string tag);
        chk({tag, " cmd"}, cmd, model_cmd);
        chk({tag, " err_code held"}, err_code, model_code);
        chk({tag, " busy idle"}, busy, 1'b0);
        chk({tag, " state idle"}, dbg_state, 3'd0);
        chk({tag, " wr_en idle"}, wr_en, 1'b0);
    endtask

    task automatic apply_vec(input int k);
        int nb;
        int n0;
        int nwr;
        string tag;
        tag = $sformatf("v%0d", k);
        clear_logs();
        nb  = vecs[k].frame.len() / 2;
        nwr = vecs[k].wdata.len() / 2;
        for (int i = 0; i < nb; i++) send_byte(hex_at(vecs[k].frame, i), GAP);
        repeat (30) @(posedge Clk);
        #1;
        chk({tag, " rx count"}, rx_q.size(), nb);
        n0 = (rx_q.size() >= nb) ? rx_q[nb - 1] : 0;
        check_burst(tag, n0, vecs[k].wdata, vecs[k].addr0, vecs[k].done, vecs[k].err,
                    vecs[k].code, vecs[k].done ? n0 + nwr + 1 : n0 + 1);
        if (vecs[k].err) model_code = vecs[k].code;
        model_cmd = vecs[k].cmd;
        post_checks(tag);
    endtask

    initial begin
        int n0;
        Rst       = 1'b1;
        Rx_Done   = 1'b0;
        data_byte = 8'h00;

        set_vec(0, "55A5011003AABBCC45", "AABBCC", 8'h10, 1, 0, 2'd0, 8'h01);
        set_vec(1, "55A5011003AABBCC46", "", 8'h10, 0, 1, 2'd0, 8'h01);
        set_vec(2, "55A5020011", "", 8'h00, 0, 1, 2'd1, 8'h01);
        set_vec(3, "5555A504FE030102030B", "010203", 8'hFE, 1, 0, 2'd0, 8'h04);
        set_vec(4, "55A507400047", "", 8'h40, 1, 0, 2'd0, 8'h07);
        set_vec(5, "55A509F810000102030405060708090A0B0C0D0E0F89",
                "000102030405060708090A0B0C0D0E0F", 8'hF8, 1, 0, 2'd0, 8'h09);

        repeat (3) @(posedge Clk);
        #1;
        chk("reset wr_en", wr_en, 1'b0);
        chk("reset wr_addr", wr_addr, 8'h00);
        chk("reset wr_data", wr_data, 8'h00);
        chk("reset cmd", cmd, 8'h00);
        chk("reset frame_done", frame_done, 1'b0);
        chk("reset frame_err", frame_err, 1'b0);
        chk("reset err_code", err_code, 2'd0);
        chk("reset busy", busy, 1'b0);
        chk("reset state", dbg_state, 3'd0);
        Rst = 1'b0;
        repeat (2) @(posedge Clk);

        for (int k = 0; k < 6; k++) apply_vec(k);

        // timeout: frame stalls after ADDR
        clear_logs();
        send_byte(8'h55, GAP);
        send_byte(8'hA5, GAP);
        send_byte(8'h03, GAP);
        send_byte(8'h20, 0);
        repeat (TIMEOUT + 10) @(posedge Clk);
        #1;
        n0 = (rx_q.size() >= 4) ? rx_q[3] : 0;
        check_burst("timeout", n0, "", 8'h00, 0, 1, 2'd2, n0 + TIMEOUT + 1);
        model_code = 2'd2;
        post_checks("timeout");
        apply_vec(0);

        // overrun: a header byte lands mid-burst
        clear_logs();
        for (int i = 0; i < 8; i++) send_byte(hex_at(vecs[0].frame, i), GAP);
        send_byte(8'h45, 0);
        send_byte(8'h55, 30);
        n0 = (rx_q.size() >= 9) ? rx_q[8] : 0;
        check_burst("overrun", n0, "AABBCC", 8'h10, 1, 1, 2'd3, n0 + 4);
        model_code = 2'd3;
        post_checks("overrun");

        // reset in the middle of DATA
        clear_logs();
        for (int i = 0; i < 6; i++) send_byte(hex_at(vecs[0].frame, i), GAP);
        chk("mid-data busy", busy, 1'b1);
        chk("mid-data state", dbg_state, 3'd5);
        Rst = 1'b1;
        #1;
        chk("mid-data reset state", dbg_state, 3'd0);
        chk("mid-data reset cmd", cmd, 8'h00);
        chk("mid-data reset err_code", err_code, 2'd0);
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;
        model_cmd  = 8'h00;
        model_code = 2'd0;
        apply_vec(0);

        // reset in the middle of the write burst
        clear_logs();
        for (int i = 0; i < 8; i++) send_byte(hex_at(vecs[0].frame, i), GAP);
        send_byte(8'h45, 0);
        @(posedge Clk); #1;
        chk("mid-burst wr_en", wr_en, 1'b1);
        #2;
        Rst = 1'b1;
        #1;
        chk("mid-burst reset wr_en", wr_en, 1'b0);
        chk("mid-burst reset cmd", cmd, 8'h00);
        repeat (3) @(posedge Clk);
        #1;
        Rst = 1'b0;
        repeat (10) @(posedge Clk);
        #1;
        chk("mid-burst write count", wr_q.size(), 1);
        chk("mid-burst no frame_done", done_q.size(), 0);
        chk("mid-burst no frame_err", err_cyc_q.size(), 0);
        model_cmd  = 8'h00;
        model_code = 2'd0;
        post_checks("mid-burst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
